qpsk_symbol_mapper: RTL and testbench

- Upstream feeder of the DA zero-insertion stage in the QPSK transmit chain.
- Accepts a serial bit stream through a valid/ready handshake and packs bits into dibits.
- Maps each dibit (Gray or differential) to signed 12-bit I/Q levels and holds each symbol for SPS clocks at 40 MHz.
- The zero-insertion stage, which samples every 4th clock, therefore always captures a stable symbol.

---
 rtl/qpsk_symbol_mapper.sv | 123 ++++++++++++
 tb/tb_qpsk_symbol_mapper.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_mapper.sv
// rtl/qpsk_symbol_mapper.sv - serial bits to Gray/DQPSK I/Q levels, each symbol held for SPS clocks
module qpsk_symbol_mapper #(
    parameter int DATA_W  = 12,
    parameter int AMP     = 1024,
    parameter int SPS     = 4,
    parameter int DIFF_EN = 0
) (
    input  logic              clk_40M,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_bit,
    input  logic              in_bit_valid,
    output logic              in_bit_ready,
    output logic [DATA_W-1:0] out_da_data0,
    output logic [DATA_W-1:0] out_da_data1,
    output logic              sym_strobe,
    output logic              underflow
);

    localparam int CNT_W = $clog2(SPS);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SPS - 1);
    localparam logic [DATA_W-1:0] POS_LVL  = DATA_W'(AMP);
    localparam logic [DATA_W-1:0] NEG_LVL  = DATA_W'(-AMP);

    logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic [1:0]        bit_cnt_q, bit_cnt_d;
    logic              b0_q, b0_d;
    logic              b1_q, b1_d;
    logic [1:0]        quad_q, quad_d;
    logic [DATA_W-1:0] i_q, i_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              strobe_q, strobe_d;
    logic              uflow_q, uflow_d;

    logic       take;
    logic       boundary;
    logic [1:0] quad_next;

    assign in_bit_ready = (bit_cnt_q < 2'd2) && !rst;

    always_comb begin
        take      = in_bit_valid && in_bit_ready;
        boundary  = enable && (sym_cnt_q == LAST_CNT);
        // {b0, b0^b1} turns the Gray dibit 00/01/11/10 into increment 0/1/2/3
        quad_next = quad_q + {b0_q, b0_q ^ b1_q};

        sym_cnt_d = sym_cnt_q;
        bit_cnt_d = bit_cnt_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        quad_d    = quad_q;
        i_d       = i_q;
        q_d       = q_q;
        strobe_d  = 1'b0;
        uflow_d   = 1'b0;

        if (take) begin
            if (bit_cnt_q == 2'd0) begin
                b0_d = in_bit;
            end else begin
                b1_d = in_bit;
            end
            bit_cnt_d = bit_cnt_q + 2'd1;
        end

        if (!enable) begin
            sym_cnt_d = '0;
            i_d       = '0;
            q_d       = '0;
        end else begin
            sym_cnt_d = boundary ? '0 : sym_cnt_q + CNT_W'(1);
            if (boundary) begin
                strobe_d = 1'b1;
                // a full dibit blocks ready, so take and this reload never coincide
                if (bit_cnt_q == 2'd2) begin
                    bit_cnt_d = 2'd0;
                    if (DIFF_EN != 0) begin
                        quad_d = quad_next;
                        i_d    = (quad_next[0] ^ quad_next[1]) ? NEG_LVL : POS_LVL;
                        q_d    = quad_next[1] ? NEG_LVL : POS_LVL;
                    end else begin
                        i_d = b0_q ? NEG_LVL : POS_LVL;
                        q_d = b1_q ? NEG_LVL : POS_LVL;
                    end
                end else begin
                    i_d     = '0;
                    q_d     = '0;
                    uflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_40M) begin
        if (rst) begin
            sym_cnt_q <= '0;
            bit_cnt_q <= 2'd0;
            b0_q      <= 1'b0;
            b1_q      <= 1'b0;
            quad_q    <= 2'd0;
            i_q       <= '0;
            q_q       <= '0;
            strobe_q  <= 1'b0;
            uflow_q   <= 1'b0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            quad_q    <= quad_d;
            i_q       <= i_d;
            q_q       <= q_d;
            strobe_q  <= strobe_d;
            uflow_q   <= uflow_d;
        end
    end

    assign out_da_data0 = i_q;
    assign out_da_data1 = q_q;
    assign sym_strobe   = strobe_q;
    assign underflow    = uflow_q;

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// tb/tb_qpsk_symbol_mapper.sv - scoreboard bench for Gray and differential mapper instances
module tb_qpsk_symbol_mapper;

    localparam int DATA_W = 12;
    localparam int AMP    = 1024;
    localparam int SPS    = 4;

    logic clk_40M = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic in_bit = 1'b0;
    logic in_bit_valid = 1'b0;

    logic              rdy_g, rdy_d;
    logic [DATA_W-1:0] i_g, q_g, i_d, q_d;
    logic              st_g, st_d, uf_g, uf_d;

    qpsk_symbol_mapper #(.DATA_W(DATA_W), .AMP(AMP), .SPS(SPS), .DIFF_EN(0)) dut_gray (
        .clk_40M(clk_40M), .rst(rst), .enable(enable), .in_bit(in_bit),
        .in_bit_valid(in_bit_valid), .in_bit_ready(rdy_g),
        .out_da_data0(i_g), .out_da_data1(q_g), .sym_strobe(st_g), .underflow(uf_g)
    );

    qpsk_symbol_mapper #(.DATA_W(DATA_W), .AMP(AMP), .SPS(SPS), .DIFF_EN(1)) dut_diff (
        .clk_40M(clk_40M), .rst(rst), .enable(enable), .in_bit(in_bit),
        .in_bit_valid(in_bit_valid), .in_bit_ready(rdy_d),
        .out_da_data0(i_d), .out_da_data1(q_d), .sym_strobe(st_d), .underflow(uf_d)
    );

    always #5 clk_40M = ~clk_40M;

    typedef struct {
        logic [DATA_W-1:0] i0;
        logic [DATA_W-1:0] q0;
        logic [DATA_W-1:0] i1;
        logic [DATA_W-1:0] q1;
        bit                uf;
    } exp_t;

    exp_t sb[$];
    bit   src[$];
    bit   pend[$];
    int   phase = 0;
    int   quad = 0;
    logic [DATA_W-1:0] h_i0 = '0, h_q0 = '0, h_i1 = '0, h_q1 = '0;
    bit   e_st = 1'b0, e_uf = 1'b0;
    bit   gate = 1'b0;
    bit   force_valid = 1'b0;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [DATA_W-1:0] lvl(input bit neg);
        return neg ? DATA_W'(-AMP) : DATA_W'(AMP);
    endfunction

    function automatic int dq_inc(input bit b0, input bit b1);
        if (!b0 && !b1) return 0;
        if (!b0 &&  b1) return 1;
        if ( b0 &&  b1) return 2;
        return 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: bits queue up, one symbol decision every SPS enabled clocks
    initial begin
        bit   rdy;
        bit   bnd;
        exp_t e;
        forever begin
            @(posedge clk_40M);
            if (rst) begin
                pend.delete();
                phase = 0;
                quad  = 0;
                h_i0 = '0; h_q0 = '0; h_i1 = '0; h_q1 = '0;
                e_st = 1'b0; e_uf = 1'b0;
            end else begin
                rdy  = pend.size() < 2;
                bnd  = enable && (phase == SPS - 1);
                e_st = 1'b0;
                e_uf = 1'b0;
                if (!enable) begin
                    phase = 0;
                    h_i0 = '0; h_q0 = '0; h_i1 = '0; h_q1 = '0;
                end else begin
                    phase = bnd ? 0 : phase + 1;
                    if (bnd) begin
                        e_st = 1'b1;
                        if (pend.size() == 2) begin
                            h_i0 = lvl(pend[0]);
                            h_q0 = lvl(pend[1]);
                            quad = (quad + dq_inc(pend[0], pend[1])) % 4;
                            h_i1 = lvl(quad == 1 || quad == 2);
                            h_q1 = lvl(quad >= 2);
                            pend.delete();
                        end else begin
                            h_i0 = '0; h_q0 = '0; h_i1 = '0; h_q1 = '0;
                            e_uf = 1'b1;
                        end
                        e = '{h_i0, h_q0, h_i1, h_q1, e_uf};
                        sb.push_back(e);
                    end
                end
                if (in_bit_valid && rdy) begin
                    pend.push_back(in_bit);
                    if (src.size() > 0) void'(src.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_40M);
            #1;
            if (force_valid) begin
                in_bit_valid = 1'b1;
                in_bit       = 1'b1;
            end else begin
                in_bit_valid = gate && (src.size() > 0);
                in_bit       = (src.size() > 0) ? src[0] : 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_40M);
            chk("ready_gray", 32'(rdy_g), 32'(!rst && pend.size() < 2));
            chk("ready_diff", 32'(rdy_d), 32'(!rst && pend.size() < 2));
            chk("strobe_gray", 32'(st_g), 32'(e_st));
            chk("strobe_diff", 32'(st_d), 32'(e_st));
            chk("underflow_gray", 32'(uf_g), 32'(e_uf));
            chk("underflow_diff", 32'(uf_d), 32'(e_uf));
            chk("hold_i_gray", 32'(i_g), 32'(h_i0));
            chk("hold_q_gray", 32'(q_g), 32'(h_q0));
            chk("hold_i_diff", 32'(i_d), 32'(h_i1));
            chk("hold_q_diff", 32'(q_d), 32'(h_q1));
            if (st_g || st_d) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_strobe", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("sym_i_gray", 32'(i_g), 32'(e.i0));
                    chk("sym_q_gray", 32'(q_g), 32'(e.q0));
                    chk("sym_i_diff", 32'(i_d), 32'(e.i1));
                    chk("sym_q_diff", 32'(q_d), 32'(e.q1));
                    chk("sym_uf", 32'(uf_g), 32'(e.uf));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_40M);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        force_valid = 1'b1;
        step(3);
        force_valid = 1'b0;
        rst = 1'b0;

        // Gray sequence: (400,400) (C00,400) (400,C00) (C00,C00)
        src = '{0, 0, 1, 0, 0, 1, 1, 1};
        gate = 1'b1;
        step(20);

        // single bit before a boundary, then completion
        for (int k = 0; k < 8 && phase != 0; k++) step(1);
        src.push_back(1'b1);
        step(6);
        src.push_back(1'b0);
        step(10);

        // DQPSK dibits 01 01 11 00
        src = '{0, 1, 0, 1, 1, 1, 0, 0};
        step(20);

        src = '{1, 0, 1, 1, 0, 1, 1, 0};
        step(6);
        enable = 1'b0;
        step(6);
        enable = 1'b1;
        step(20);

        // reset with one bit held and a symbol on the outputs
        src = '{1, 1, 0, 1};
        step(4);
        src = '{1};
        for (int k = 0; k < 12 && pend.size() != 1; k++) step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        src = '{0, 1, 1, 0};
        step(14);

        for (int n = 0; n < 1500; n++) begin
            gate = ($urandom_range(0, 3) != 0);
            while (src.size() < 4) src.push_back(bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            rst = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rst = 1'b0;
        enable = 1'b0;
        step(4);
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
